// File: rtl/heroe_pkg.sv
// Shared definitions for the keypad scanner: matrix geometry, FSM states and
// the row priority encoder.
package heroe_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Rows are active-low; when several are low the lowest index wins.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks;
// shared by the keypad scanner and the display multiplexer.
module scan_tick_gen #(
  parameter int SCAN_DIV = 1350
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces
// the synchronized rows and reports one code per confirmed press.
module keypad_scanner
  import heroe_pkg::*;
#(
  parameter int SCAN_DIV       = 1350,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic                tick;
  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  state_t              state;
  logic [1:0]          cur_col;
  logic [1:0]          row_idx;
  logic [CNT_W-1:0]    deb_cnt;
  logic [CNT_W-1:0]    rel_cnt;
  logic                any_low;
  logic [1:0]          sel_row;
  logic                row_hit;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign any_low = ~&row_sync;
  assign sel_row = lowest_low_row(row_sync);
  assign row_hit = ~row_sync[row_idx];

  // The column stays frozen outside SCAN, so cur_col doubles as the latched
  // column index of the key being debounced or held.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta  <= '1;
      row_sync  <= '1;
      state     <= SCAN;
      cur_col   <= 2'd0;
      col_out   <= 4'b1110;
      row_idx   <= 2'd0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_meta  <= row_in;
      row_sync  <= row_meta;
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              row_idx <= sel_row;
              if (DEBOUNCE_TICKS == 1) begin
                key_code  <= {sel_row, cur_col};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= HELD;
              end else begin
                deb_cnt <= CNT_W'(1);
                state   <= DEBOUNCE;
              end
            end else begin
              cur_col <= cur_col + 2'd1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
          DEBOUNCE: begin
            if (row_hit) begin
              if (deb_cnt == CNT_LAST) begin
                key_code  <= {row_idx, cur_col};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                deb_cnt   <= '0;
                state     <= HELD;
              end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
              end
            end else begin
              deb_cnt <= '0;
              state   <= SCAN;
              cur_col <= cur_col + 2'd1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
          HELD: begin
            if (!row_hit) begin
              if (rel_cnt == CNT_LAST) begin
                key_held <= 1'b0;
                rel_cnt  <= '0;
                state    <= SCAN;
                cur_col  <= cur_col + 2'd1;
                col_out  <= {col_out[2:0], col_out[3]};
              end else begin
                rel_cnt <= rel_cnt + CNT_W'(1);
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
